// File: rtl/dac_segmented_dem.sv
// Segmented DAC encoder: thermometer-decoded MSBs with selectable dynamic element
// matching (static, DWA, LFSR rotation) and binary LSB pass-through, one-cycle latency.
module dac_segmented_dem #(
  parameter int MSB_BITS = 4,
  parameter int LSB_BITS = 4,
  localparam int N_EL = (1 << MSB_BITS) - 1,
  localparam int LW = (LSB_BITS > 0) ? LSB_BITS : 1,
  localparam int CW = MSB_BITS + LSB_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CW-1:0]       code,
  input  logic                code_valid,
  output logic                code_ready,
  input  logic                freeze,
  input  logic [1:0]          dem_mode,
  output logic [N_EL-1:0]     therm,
  output logic [LW-1:0]       lsb,
  output logic                out_update,
  output logic [MSB_BITS-1:0] ptr
);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  logic [15:0]         lfsr_r;
  logic [1:0]          prev_mode_r;
  logic                accept_s;
  logic [1:0]          mode_s;
  logic [MSB_BITS-1:0] k_s;
  logic [MSB_BITS-1:0] ptr_base_s;
  logic [MSB_BITS-1:0] start_s;
  logic [MSB_BITS-1:0] ptr_next_s;
  logic [MSB_BITS:0]   dwa_sum_s;
  logic [15:0]         lfsr_mod_s;
  logic [N_EL-1:0]     therm_next_s;
  logic [LW-1:0]       lsb_next_s;

  assign code_ready = !freeze;

  // Accept decode, rotation start selection and pointer update.
  always_comb begin
    accept_s   = code_valid && !freeze;
    mode_s     = (dem_mode == 2'd3) ? 2'd0 : dem_mode;
    k_s        = code[CW-1:LSB_BITS];
    // A mode switch realigns the rotation to element 0 for that sample.
    ptr_base_s = (mode_s != prev_mode_r) ? {MSB_BITS{1'b0}} : ptr;
    dwa_sum_s  = {1'b0, ptr_base_s} + {1'b0, k_s};
    lfsr_mod_s = lfsr_r % 16'(N_EL);
    start_s    = {MSB_BITS{1'b0}};
    ptr_next_s = {MSB_BITS{1'b0}};
    case (mode_s)
      2'd1: begin
        start_s = ptr_base_s;
        if (dwa_sum_s >= (MSB_BITS+1)'(N_EL)) begin
          ptr_next_s = MSB_BITS'(dwa_sum_s - (MSB_BITS+1)'(N_EL));
        end else begin
          ptr_next_s = dwa_sum_s[MSB_BITS-1:0];
        end
      end
      2'd2: begin
        start_s    = lfsr_mod_s[MSB_BITS-1:0];
        ptr_next_s = lfsr_mod_s[MSB_BITS-1:0];
      end
      default: begin
        start_s    = {MSB_BITS{1'b0}};
        ptr_next_s = {MSB_BITS{1'b0}};
      end
    endcase
    if (LSB_BITS > 0) begin
      lsb_next_s = code[LW-1:0];
    end else begin
      lsb_next_s = {LW{1'b0}};
    end
  end

  // Element i is on when its distance from start, modulo N_EL, is below k.
  always_comb begin
    therm_next_s = {N_EL{1'b0}};
    for (int i = 0; i < N_EL; i++) begin
      int d;
      d = i + N_EL - int'(start_s);
      if (d >= N_EL) begin
        d = d - N_EL;
      end else begin
        d = d;
      end
      therm_next_s[i] = (d < int'(k_s));
    end
  end

  // Output, pointer, LFSR and mode history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      therm       <= {N_EL{1'b0}};
      lsb         <= {LW{1'b0}};
      out_update  <= 1'b0;
      ptr         <= {MSB_BITS{1'b0}};
      lfsr_r      <= LFSR_SEED;
      prev_mode_r <= 2'd0;
    end else if (accept_s) begin
      therm       <= therm_next_s;
      lsb         <= lsb_next_s;
      out_update  <= 1'b1;
      ptr         <= ptr_next_s;
      lfsr_r      <= lfsr_step(lfsr_r);
      prev_mode_r <= mode_s;
    end else begin
      out_update  <= 1'b0;
    end
  end

endmodule

// File: doc/dac_segmented_dem.md
DAC_SEGMENTED_DEM -- requirements
Module: dac_segmented_dem

Interface
REQ-001 Parameter MSB_BITS, default 4, number of thermometer-decoded MSBs; legal range 2..6.
REQ-002 Parameter LSB_BITS, default 4, number of binary-weighted LSBs passed through; legal range 0..8.
REQ-003 Derived constant N_EL = 2^MSB_BITS - 1, the number of unary elements.
REQ-004 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, rising-edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 code  input  MSB_BITS+LSB_BITS  unsigned DAC input code; MSB field = code[MSB_BITS+LSB_BITS-1:LSB_BITS].
REQ-008 code_valid  input  1  code is presented this cycle.
REQ-009 code_ready  output  1  block accepts code this cycle.
REQ-010 freeze  input  1  stall; outputs hold, no accept.
REQ-011 dem_mode  input  2  0 = static thermometer, 1 = data-weighted averaging (DWA), 2 = pseudo-random rotation, 3 = reserved (treated as 0).
REQ-012 therm  output  N_EL  registered unary element enables.
REQ-013 lsb  output  LSB_BITS  registered binary LSB field (absent when LSB_BITS = 0).
REQ-014 out_update  output  1  single-cycle pulse, high the cycle therm/lsb take a new value.
REQ-015 ptr  output  MSB_BITS  current rotation pointer, range 0..N_EL-1, for debug/observability.

Function
REQ-016 code_ready SHALL equal !freeze (combinational); accept = code_valid && code_ready.
REQ-017 Latency SHALL be one cycle: a code accepted at edge t appears on therm/lsb after edge t, with out_update high for exactly that cycle.
REQ-018 Without an accept, therm, lsb and ptr SHALL hold and out_update SHALL be 0.
REQ-019 Let k = MSB field (0..N_EL); exactly k bits of therm SHALL be set after each accept, in every mode.
REQ-020 Mode 0: therm bits 0..k-1 set; ptr forced to 0.
REQ-021 Mode 1 (DWA): therm bits (ptr+i) mod N_EL for i = 0..k-1 set, using ptr before the accept; ptr SHALL then update to (ptr+k) mod N_EL.
REQ-022 Mode 2: start index s = lfsr mod N_EL, using the LFSR value before the accept; therm bits (s+i) mod N_EL set; ptr SHALL update to s.
REQ-023 LFSR SHALL be 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, reset seed 16'hACE1, advancing once per accept in every mode.
REQ-024 When an accept's dem_mode differs from the mode of the previous accept, ptr SHALL be treated as 0 for that sample (mode-change realignment).
REQ-025 Boundaries: k = 0 -> therm all 0, ptr unchanged in mode 1; k = N_EL -> therm all 1, ptr unchanged in mode 1; wrap-around SHALL be modulo N_EL, never 2^MSB_BITS.
REQ-026 lsb SHALL equal code[LSB_BITS-1:0] of the accepted code, unmodified, in every mode.
REQ-027 freeze asserted together with code_valid SHALL block the accept; the code is not consumed.

Reset
REQ-028 On rst_n low, immediately and regardless of clk: therm = 0, lsb = 0, out_update = 0, ptr = 0, LFSR = 16'hACE1, previous-mode register = 0.
REQ-029 Reset asserted mid-stream SHALL discard any accept in that cycle; the first accept after release is processed as the first sample after power-up.

Verification (MSB_BITS = 4, LSB_BITS = 4, N_EL = 15)
REQ-030 Mode 0, accept code 8'h5A -> next cycle therm = 15'h001F, lsb = 4'hA, out_update = 1 for one cycle, ptr = 0.
REQ-031 Mode 1 from reset, accept MSB fields 5, 5, 7 -> therm = 15'h001F, 15'h03E0, 15'h7C03; ptr = 5, 10, 2.
REQ-032 Mode 1, accept k = 15 then k = 0 -> therm = 15'h7FFF then 15'h0000; ptr unchanged throughout.
REQ-033 Mode 2 from reset, accept k = 3 -> s = 44257 mod 15 = 7, therm = 15'h0380, ptr = 7.
REQ-034 freeze = 1 with code_valid = 1 for 3 cycles -> code_ready = 0, out_update = 0, outputs and ptr hold; rst_n pulsed low mid-stream -> all outputs 0 asynchronously, next DWA sample starts at ptr 0.
